bus_fifo_arbiter: RTL

- Shares one bus_fifo write port between N producer requesters.
- Uses round-robin arbitration with burst locking: an owner keeps the FIFO until its burst ends, a burst cap is reached, or it abandons the request.
- Sits between bus-slave producer logic and the bus_fifo DATA_STROBE/DATA_IN/FULL interface.
- Also counts back-pressure (stall) cycles for debug.

---
 rtl/bus_fifo_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bus_fifo_arbiter.sv
// Purpose : shares one bus_fifo write port between `requesters` producers using
//           round-robin arbitration with burst locking, and counts FIFO stall cycles.
// Latency : 1 cycle from REQ_VALID to GRANT; beats pass combinationally while owned.
// Backpressure: FIFO_FULL freezes the owner's burst (no strobe, no ACK) and bumps STALL_COUNT.
//
// Ports:
//   CLK, RESET    clock; asynchronous active-high reset
//   REQ_VALID/DATA/LAST  per-requester beat valid, flattened data, last-beat marker
//   REQ_ACK       one-hot beat-accept pulse to the owner
//   GRANT         one-hot registered owner, zero when idle
//   FIFO_STROBE/DATA/FULL  bus_fifo write interface
//   STALL_COUNT   saturating count of owner cycles blocked by FIFO_FULL
module bus_fifo_arbiter #(
   parameter int width      = 8,
   parameter int requesters = 4,
   parameter int max_burst  = 4
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [requesters-1:0]         REQ_VALID,
   input  logic [width*requesters-1:0]   REQ_DATA,
   input  logic [requesters-1:0]         REQ_LAST,
   output logic [requesters-1:0]         REQ_ACK,
   output logic [requesters-1:0]         GRANT,
   output logic                          FIFO_STROBE,
   output logic [width-1:0]              FIFO_DATA,
   input  logic                          FIFO_FULL,
   output logic [15:0]                   STALL_COUNT
);

   localparam int IDX_W = $clog2(requesters);

   typedef enum logic {IDLE, OWN} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [7:0]              burst_q, burst_d;
   logic [15:0]             stall_q, stall_d;
   logic [requesters-1:0]   grant_q, grant_d;

   logic [width-1:0]        slice [requesters];
   logic [IDX_W-1:0]        cand;
   logic [IDX_W-1:0]        pick;
   logic                    pick_vld;
   logic                    own_vld;
   logic                    accept;
   logic [7:0]              burst_inc;

   always_comb begin
      for (int i = 0; i < requesters; i++) begin
         slice[i] = REQ_DATA[i*width +: width];
      end
   end

   // Rotating-priority search: start just above the previous owner and wrap,
   // so the most recent owner is considered last.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int k = 1; k <= requesters; k++) begin
         cand = IDX_W'((int'(last_q) + k) % requesters);
         if (!pick_vld && REQ_VALID[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   assign own_vld   = REQ_VALID[owner_q];
   assign accept    = (state_q == OWN) && own_vld && !FIFO_FULL;
   assign burst_inc = burst_q + 8'd1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      stall_d = stall_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d       = OWN;
               owner_d       = pick;
               burst_d       = '0;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
            end
         end
         OWN: begin
            if (!own_vld) begin
               // Owner abandoned its request.
               state_d = IDLE;
               grant_d = '0;
               last_d  = owner_q;
               burst_d = '0;
            end else if (FIFO_FULL) begin
               // Burst count frozen; only the debug counter moves.
               if (stall_q != 16'hFFFF) begin
                  stall_d = stall_q + 16'd1;
               end
            end else if (REQ_LAST[owner_q] || (burst_inc == 8'(max_burst))) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = owner_q;
               burst_d = '0;
            end else begin
               burst_d = burst_inc;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IDX_W'(requesters - 1);
         burst_q <= '0;
         stall_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         stall_q <= stall_d;
         grant_q <= grant_d;
      end
   end

   // grant_q is one-hot on the owner while in OWN, so it doubles as the ACK mask.
   assign REQ_ACK     = accept ? grant_q : '0;
   assign FIFO_STROBE = accept;
   assign FIFO_DATA   = accept ? slice[owner_q] : '0;
   assign GRANT       = grant_q;
   assign STALL_COUNT = stall_q;

endmodule
